hamming_tx_arbiter: RTL and testbench



---
 rtl/hamming_tx_arbiter_if.sv | 46 ++++
 rtl/hamming_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_hamming_tx_arbiter.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_tx_arbiter_if.sv
// Requester handshakes, stall control and serial line of the
// Hamming(7,4) transmit arbiter.
interface hamming_tx_arbiter_if;
  logic       req0_valid;
  logic [3:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [3:0] req1_data;
  logic       req1_ready;
  logic       stall;
  logic       serial_out;
  logic       write;
  logic       frame_start;
  logic       grant_id;
  logic       busy;

  modport master (
    output req0_valid,
    output req0_data,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    input  req1_ready,
    output stall,
    input  serial_out,
    input  write,
    input  frame_start,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req0_valid,
    input  req0_data,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    output req1_ready,
    input  stall,
    output serial_out,
    output write,
    output frame_start,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/hamming_tx_arbiter.sv
// Round-robin arbiter over two 4-bit requesters feeding a
// Hamming(7,4) encoder and a stallable serial bit shifter.
module hamming_tx_arbiter #(
  parameter int GAP_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  hamming_tx_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [3:0] GAP_LAST =
    (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  logic [1:0] state;
  logic [7:0] cw_q;
  logic [2:0] idx;
  logic [3:0] gap_cnt;
  logic       last_grant;

  logic       ser_q;
  logic       wr_q;
  logic       fs_q;
  logic       gid_q;
  logic       busy_q;

  logic       pick;
  logic       take;
  logic [3:0] pick_data;
  logic [6:0] cw_new;

  // bit 0 is codeword position 1 (first on the wire)
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      bus.req0_valid && bus.req1_valid: pick = ~last_grant;
      bus.req1_valid && !bus.req0_valid: pick = 1'b1;
      default: pick = 1'b0;
    endcase
    pick_data = pick ? bus.req1_data : bus.req0_data;
    take = (state == IDLE) &&
           (bus.req0_valid || bus.req1_valid);
    cw_new = encode(pick_data);
  end

  assign bus.req0_ready = take & ~pick;
  assign bus.req1_ready = take & pick;

  // idx is the next bit to present; 7 means the frame is out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cw_q       <= '0;
      idx        <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      ser_q      <= 1'b0;
      wr_q       <= 1'b0;
      fs_q       <= 1'b0;
      gid_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      fs_q <= 1'b0;
      unique case (state)
        IDLE: begin
          ser_q <= 1'b0;
          wr_q  <= 1'b0;
          if (take) begin
            state      <= SHIFT;
            cw_q       <= {1'b0, cw_new};
            idx        <= 3'd1;
            ser_q      <= cw_new[0];
            wr_q       <= 1'b1;
            fs_q       <= 1'b1;
            gid_q      <= pick;
            last_grant <= pick;
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          if (idx == 3'd7) begin
            ser_q <= 1'b0;
            wr_q  <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LAST;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else if (bus.stall) begin
            wr_q <= 1'b0;
          end else begin
            ser_q <= cw_q[idx];
            wr_q  <= 1'b1;
            idx   <= idx + 3'd1;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.serial_out  = ser_q;
  assign bus.write       = wr_q;
  assign bus.frame_start = fs_q;
  assign bus.grant_id    = gid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_hamming_tx_arbiter.sv
// Bench for hamming_tx_arbiter: directed scenarios plus a
// randomized run against a frame-level reference model.
module tb_hamming_tx_arbiter;
  localparam int GAP1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  hamming_tx_arbiter_if b();
  hamming_tx_arbiter_if z();

  hamming_tx_arbiter #(.GAP_CYCLES(GAP1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b.slave)
  );

  hamming_tx_arbiter #(.GAP_CYCLES(0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(z.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // generic Hamming rule: parity at power-of-two positions
  // covers every position sharing that bit; data fills the rest
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [7:1] w;
    logic [6:0] c;
    int j;
    w = '0;
    j = 0;
    for (int p = 1; p <= 7; p++) begin
      if (p != 1 && p != 2 && p != 4) begin
        w[p] = d[j];
        j++;
      end
    end
    for (int p = 1; p <= 4; p = p * 2) begin
      for (int q = 1; q <= 7; q++)
        if ((q & p) != 0 && q != p) w[p] = w[p] ^ w[q];
    end
    for (int k = 0; k < 7; k++) c[k] = w[k + 1];
    return c;
  endfunction

  task automatic test_reset();
    logic [6:0] e;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({b.serial_out, b.write, b.frame_start,
         b.grant_id, b.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 00000",
        {b.serial_out, b.write, b.frame_start,
         b.grant_id, b.busy});
    end
    rst = 1'b0;
    b.req1_valid = 1'b1;
    b.req1_data = 4'b1111;
    @(posedge clk);
    #1 b.req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({b.serial_out, b.write, b.frame_start,
         b.grant_id, b.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_async: got %b want 00000",
        {b.serial_out, b.write, b.frame_start,
         b.grant_id, b.busy});
    end
    @(negedge clk);
    rst = 1'b0;
    b.req0_valid = 1'b1;
    b.req0_data = 4'b0001;
    b.req1_valid = 1'b1;
    b.req1_data = 4'b0001;
    #1;
    vectors++;
    if ({b.req0_ready, b.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_first_grant: got %b want 10",
        {b.req0_ready, b.req1_ready});
    end
    @(posedge clk);
    #1;
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    e = enc(4'b0001);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vectors++;
      if ({b.write, b.serial_out, b.frame_start, b.grant_id}
          !== {1'b1, e[k], k == 0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_frame bit%0d: got %b want %b", k,
          {b.write, b.serial_out, b.frame_start, b.grant_id},
          {1'b1, e[k], k == 0, 1'b0});
      end
    end
    @(negedge clk);
    vectors++;
    if (b.write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_end: write %b want 0", b.write);
    end
  endtask

  task automatic test_gap1();
    logic [6:0] bits;
    int nw, nb, nf, fs_pos;
    repeat (4) @(negedge clk);
    b.req0_valid = 1'b1;
    b.req0_data = 4'b1011;
    #1;
    vectors++;
    if (b.req0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL gap1_ready: got %b want 1", b.req0_ready);
    end
    @(posedge clk);
    #1 b.req0_valid = 1'b0;
    bits = '0;
    nw = 0;
    nb = 0;
    nf = 0;
    fs_pos = -1;
    repeat (12) begin
      @(negedge clk);
      if (b.frame_start === 1'b1) begin
        nf++;
        fs_pos = nw;
      end
      if (b.write === 1'b1) begin
        if (nw < 7) bits[nw] = b.serial_out;
        nw++;
      end
      if (b.busy === 1'b1) nb++;
    end
    vectors++;
    if (bits !== 7'b1010101 || bits !== enc(4'b1011)) begin
      miscompares++;
      $display("FAIL gap1_bits: got %b want 1010101", bits);
    end
    vectors++;
    if (nw != 7) begin
      miscompares++;
      $display("FAIL gap1_writes: got %0d want 7", nw);
    end
    vectors++;
    if (nb != 8) begin
      miscompares++;
      $display("FAIL gap1_busy: got %0d want 8", nb);
    end
    vectors++;
    if (nf != 1 || fs_pos != 0) begin
      miscompares++;
      $display("FAIL gap1_frame_start: count %0d at %0d want 1 at 0",
        nf, fs_pos);
    end
  endtask

  task automatic test_stall();
    logic [6:0] e;
    int nb;
    repeat (4) @(negedge clk);
    e = enc(4'b1011);
    nb = 0;
    b.req0_valid = 1'b1;
    b.req0_data = 4'b1011;
    @(posedge clk);
    #1 b.req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (b.busy === 1'b1) nb++;
      vectors++;
      if ({b.write, b.serial_out} !== {1'b1, e[k]}) begin
        miscompares++;
        $display("FAIL stall_pre bit%0d: got %b want %b", k,
          {b.write, b.serial_out}, {1'b1, e[k]});
      end
    end
    b.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      if (b.busy === 1'b1) nb++;
      vectors++;
      if ({b.write, b.serial_out} !== 2'b01) begin
        miscompares++;
        $display("FAIL stall_hold cyc%0d: got %b want 01", s,
          {b.write, b.serial_out});
      end
    end
    b.stall = 1'b0;
    for (int k = 3; k < 7; k++) begin
      @(negedge clk);
      if (b.busy === 1'b1) nb++;
      vectors++;
      if ({b.write, b.serial_out} !== {1'b1, e[k]}) begin
        miscompares++;
        $display("FAIL stall_post bit%0d: got %b want %b", k,
          {b.write, b.serial_out}, {1'b1, e[k]});
      end
    end
    repeat (4) begin
      @(negedge clk);
      if (b.busy === 1'b1) nb++;
    end
    vectors++;
    if (nb != 11) begin
      miscompares++;
      $display("FAIL stall_busy: got %0d want 11", nb);
    end
  endtask

  task automatic test_alternate();
    int starts[4];
    logic grants[4];
    logic [6:0] fb[4];
    int nf, pos;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b.req0_valid = 1'b1;
    b.req0_data = 4'b0000;
    b.req1_valid = 1'b1;
    b.req1_data = 4'b1111;
    nf = 0;
    pos = 0;
    for (int i = 0; i < 4; i++) begin
      starts[i] = 0;
      grants[i] = 1'bx;
      fb[i] = 'x;
    end
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (b.frame_start === 1'b1 && nf < 4) begin
        starts[nf] = cyc;
        grants[nf] = b.grant_id;
        nf++;
        pos = 0;
      end
      if (b.write === 1'b1 && nf > 0 && pos < 7) begin
        fb[nf - 1][pos] = b.serial_out;
        pos++;
      end
      if (nf == 4 && pos == 7) break;
    end
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    vectors++;
    if (nf != 4 || pos != 7) begin
      miscompares++;
      $display("FAIL alt_timeout: frames %0d bits %0d want 4 7",
        nf, pos);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (grants[i] !== 1'(i % 2)) begin
        miscompares++;
        $display("FAIL alt_grant%0d: got %b want %0d", i,
          grants[i], i % 2);
      end
      vectors++;
      if (fb[i] !== ((i % 2 == 1) ? 7'h7f : 7'h00)) begin
        miscompares++;
        $display("FAIL alt_bits%0d: got %b", i, fb[i]);
      end
      if (i > 0) begin
        vectors++;
        if (starts[i] - starts[i - 1] != 9) begin
          miscompares++;
          $display("FAIL alt_spacing%0d: got %0d want 9", i,
            starts[i] - starts[i - 1]);
        end
      end
    end
  endtask

  task automatic test_gap0();
    logic [6:0] e;
    int starts[3];
    int zc[3];
    int nf, pos, zcount;
    repeat (4) @(negedge clk);
    e = enc(4'b0110);
    z.req0_valid = 1'b1;
    z.req0_data = 4'b0110;
    nf = 0;
    pos = 0;
    zcount = 0;
    for (int i = 0; i < 3; i++) begin
      starts[i] = 0;
      zc[i] = -1;
    end
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (z.frame_start === 1'b1 && nf < 3) begin
        starts[nf] = cyc;
        if (nf > 0) zc[nf - 1] = zcount;
        zcount = 0;
        nf++;
        pos = 0;
      end
      if (z.write === 1'b1) begin
        if (nf > 0 && pos < 7) begin
          vectors++;
          if (z.serial_out !== e[pos]) begin
            miscompares++;
            $display("FAIL gap0_bit f%0d b%0d: got %b want %b",
              nf - 1, pos, z.serial_out, e[pos]);
          end
          pos++;
        end
      end else if (nf > 0) begin
        zcount++;
      end
      if (nf == 3 && pos == 7) break;
    end
    z.req0_valid = 1'b0;
    vectors++;
    if (nf != 3 || pos != 7) begin
      miscompares++;
      $display("FAIL gap0_timeout: frames %0d bits %0d", nf, pos);
    end
    for (int i = 1; i < 3; i++) begin
      vectors++;
      if (starts[i] - starts[i - 1] != 8) begin
        miscompares++;
        $display("FAIL gap0_spacing%0d: got %0d want 8", i,
          starts[i] - starts[i - 1]);
      end
      vectors++;
      if (zc[i - 1] != 1) begin
        miscompares++;
        $display("FAIL gap0_idle%0d: got %0d want 1", i,
          zc[i - 1]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] q_cw[$];
    logic q_g[$];
    logic [6:0] cur;
    logic curg, last, win, v0, v1;
    logic [3:0] d0, d1;
    logic [1:0] expr;
    int pos, idle_at;
    bit inframe, idle;
    rst = 1'b1;
    b.stall = 1'b0;
    b.req0_valid = 1'b0;
    b.req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last = 1'b1;
    pos = 7;
    idle_at = 0;
    inframe = 1'b0;
    cur = '0;
    curg = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    d0 = '0;
    d1 = '0;
    for (int n = 0; n < 1520; n++) begin
      @(negedge clk);
      if (b.frame_start === 1'b1) begin
        vectors++;
        if (b.write !== 1'b1 || pos != 7 ||
            q_cw.size() == 0) begin
          miscompares++;
          $display("FAIL rand_start: write %b pos %0d pending %0d",
            b.write, pos, q_cw.size());
        end else begin
          cur = q_cw.pop_front();
          curg = q_g.pop_front();
          pos = 0;
          vectors++;
          if (b.grant_id !== curg) begin
            miscompares++;
            $display("FAIL rand_grant: got %b want %b",
              b.grant_id, curg);
          end
        end
      end
      if (b.write === 1'b1) begin
        vectors++;
        if (pos >= 7) begin
          miscompares++;
          $display("FAIL rand_extra_write: cycle %0d", cyc);
        end else begin
          if (b.serial_out !== cur[pos]) begin
            miscompares++;
            $display("FAIL rand_bit%0d: got %b want %b", pos,
              b.serial_out, cur[pos]);
          end
          pos++;
          if (pos == 7) begin
            inframe = 1'b0;
            idle_at = cyc + 1 + GAP1;
          end
        end
      end
      if (b.busy !== 1'b1) begin
        vectors++;
        if ({b.serial_out, b.write} !== 2'b00) begin
          miscompares++;
          $display("FAIL rand_idle_line: got %b want 00",
            {b.serial_out, b.write});
        end
      end
      idle = !inframe && (cyc >= idle_at);
      win = (v0 && v1) ? ~last : v1;
      expr = (idle && (v0 || v1)) ?
             (win ? 2'b01 : 2'b10) : 2'b00;
      vectors++;
      if ({b.req0_ready, b.req1_ready} !== expr) begin
        miscompares++;
        $display("FAIL rand_ready: got %b want %b at %0d",
          {b.req0_ready, b.req1_ready}, expr, cyc);
      end
      if (expr != 2'b00) begin
        q_cw.push_back(enc(win ? d1 : d0));
        q_g.push_back(win);
        last = win;
        inframe = 1'b1;
      end
      @(posedge clk);
      #1;
      if (n >= 1500) begin
        v0 = 1'b0;
        v1 = 1'b0;
        b.stall = 1'b0;
      end else begin
        if (expr == 2'b10 || !v0) begin
          v0 = ($urandom_range(0, 2) != 0);
          d0 = 4'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          v0 = 1'b0;
        end
        if (expr == 2'b01 || !v1) begin
          v1 = ($urandom_range(0, 2) != 0);
          d1 = 4'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          v1 = 1'b0;
        end
        b.stall = ($urandom_range(0, 3) == 0);
      end
      b.req0_valid = v0;
      b.req0_data = d0;
      b.req1_valid = v1;
      b.req1_data = d1;
    end
    vectors++;
    if (q_cw.size() != 0 || pos != 7) begin
      miscompares++;
      $display("FAIL rand_drain: pending %0d pos %0d",
        q_cw.size(), pos);
    end
  endtask

  initial begin
    b.req0_valid = 1'b0;
    b.req0_data = '0;
    b.req1_valid = 1'b0;
    b.req1_data = '0;
    b.stall = 1'b0;
    z.req0_valid = 1'b0;
    z.req0_data = '0;
    z.req1_valid = 1'b0;
    z.req1_data = '0;
    z.stall = 1'b0;
    test_reset();
    test_gap1();
    test_stall();
    test_alternate();
    test_gap0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end
endmodule
